// File: rtl/dispense_mech.sv
// dispense_mech: responder-side sequencer for the cup-drop motor and coffee valve.
// Handles the Place_cup/Cup_rdy and Inject_cof/Cof_rdy four-phase handshakes.
// Times each drop and pour with one shared down-counter and reports cup faults.
module dispense_mech #(
   parameter int unsigned CUP_CYCLES  = 50,
   parameter int unsigned POUR_CYCLES = 200
) (
   input  logic Clock,
   input  logic Reset_n,
   input  logic Place_cup,
   input  logic Inject_cof,
   input  logic Cup_sensor,
   output logic Cup_rdy,
   output logic Cof_rdy,
   output logic Cup_motor,
   output logic Valve_open,
   output logic Busy,
   output logic Fault
);

   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CUP_LOAD  = CNT_W'(CUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] POUR_LOAD = CNT_W'(POUR_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DROP,
      S_CUP_OK,
      S_HOLD,
      S_POUR,
      S_COF_OK,
      S_REMOVE,
      S_FAULT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       sync_q;
   logic             sens_s;
   logic             cnt_zero;

   logic cup_rdy_d, cof_rdy_d, cup_motor_d, valve_open_d, busy_d, fault_d;

   assign sens_s   = sync_q[1];
   assign cnt_zero = (cnt_q == '0);

   // Two-flop synchronizer for the asynchronous cup sensor.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], Cup_sensor};
      end
   end

   // State and shared phase counter.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter update and Moore decode of the next state.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cup_rdy_d    = 1'b0;
      cof_rdy_d    = 1'b0;
      cup_motor_d  = 1'b0;
      valve_open_d = 1'b0;
      busy_d       = 1'b0;
      fault_d      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            // Place_cup has priority; a lone Inject_cof is ignored here.
            if (Place_cup) begin
               state_d = S_DROP;
               cnt_d   = CUP_LOAD;
            end
         end
         S_DROP: begin
            if (cnt_zero) begin
               state_d = sens_s ? S_CUP_OK : S_FAULT;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_CUP_OK: begin
            // Losing the cup outranks the handshake.
            if (!sens_s) begin
               state_d = S_FAULT;
            end else if (!Place_cup) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!sens_s) begin
               state_d = S_IDLE;
            end else if (Inject_cof) begin
               state_d = S_POUR;
               cnt_d   = POUR_LOAD;
            end
         end
         S_POUR: begin
            // Cup pulled mid-pour closes the valve on the next edge.
            if (!sens_s) begin
               state_d = S_FAULT;
            end else if (cnt_zero) begin
               state_d = S_COF_OK;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_COF_OK: begin
            if (!Inject_cof) begin
               state_d = S_REMOVE;
            end
         end
         S_REMOVE: begin
            // A new Place_cup waits until the served cup is gone.
            if (!sens_s) begin
               state_d = S_IDLE;
            end
         end
         S_FAULT: begin
            if (!Place_cup && !Inject_cof && !sens_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      cup_rdy_d    = (state_d == S_CUP_OK);
      cof_rdy_d    = (state_d == S_COF_OK);
      cup_motor_d  = (state_d == S_DROP);
      valve_open_d = (state_d == S_POUR);
      busy_d       = (state_d != S_IDLE);
      fault_d      = (state_d == S_FAULT);
   end

   // Registered outputs, aligned with the state register.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Cup_rdy    <= 1'b0;
         Cof_rdy    <= 1'b0;
         Cup_motor  <= 1'b0;
         Valve_open <= 1'b0;
         Busy       <= 1'b0;
         Fault      <= 1'b0;
      end else begin
         Cup_rdy    <= cup_rdy_d;
         Cof_rdy    <= cof_rdy_d;
         Cup_motor  <= cup_motor_d;
         Valve_open <= valve_open_d;
         Busy       <= busy_d;
         Fault      <= fault_d;
      end
   end

endmodule

// File: tb/tb_dispense_mech.sv
// tb_dispense_mech: directed scenarios plus randomized traffic for dispense_mech.
// Expected outputs come from a timestamp-based phase model of the sequencer.
module tb_dispense_mech;

   localparam int unsigned CUP_N  = 5;
   localparam int unsigned POUR_N = 8;

   logic Clock      = 1'b0;
   logic Reset_n    = 1'b1;
   logic Place_cup  = 1'b0;
   logic Inject_cof = 1'b0;
   logic Cup_sensor = 1'b0;
   logic Cup_rdy, Cof_rdy, Cup_motor, Valve_open, Busy, Fault;

   dispense_mech #(.CUP_CYCLES(CUP_N), .POUR_CYCLES(POUR_N)) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Place_cup  (Place_cup),
      .Inject_cof (Inject_cof),
      .Cup_sensor (Cup_sensor),
      .Cup_rdy    (Cup_rdy),
      .Cof_rdy    (Cof_rdy),
      .Cup_motor  (Cup_motor),
      .Valve_open (Valve_open),
      .Busy       (Busy),
      .Fault      (Fault)
   );

   always #5 Clock = ~Clock;

   typedef enum int {M_IDLE, M_DROP, M_CUPOK, M_HOLD, M_POUR, M_COFOK, M_REMOVE, M_FAULT} mphase_t;

   mphase_t     ph = M_IDLE;
   int unsigned edge_n = 0;
   int unsigned t_end = 0;
   bit          sq[$];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Sensor as the FSM sees it: the raw value sampled two edges earlier, 0 after reset.
   function automatic bit seen_sensor();
      if (sq.size() >= 2) return sq[sq.size()-2];
      return 1'b0;
   endfunction

   task automatic model_edge(input bit pc, input bit ic, input bit cs);
      bit s;
      s = seen_sensor();
      edge_n++;
      case (ph)
         M_IDLE:   if (pc) begin ph = M_DROP; t_end = edge_n + CUP_N; end
         M_DROP:   if (edge_n == t_end) ph = s ? M_CUPOK : M_FAULT;
         M_CUPOK:  if (!s) ph = M_FAULT; else if (!pc) ph = M_HOLD;
         M_HOLD:   if (!s) ph = M_IDLE;
                   else if (ic) begin ph = M_POUR; t_end = edge_n + POUR_N; end
         M_POUR:   if (!s) ph = M_FAULT; else if (edge_n == t_end) ph = M_COFOK;
         M_COFOK:  if (!ic) ph = M_REMOVE;
         M_REMOVE: if (!s) ph = M_IDLE;
         M_FAULT:  if (!pc && !ic && !s) ph = M_IDLE;
         default:  ph = M_IDLE;
      endcase
      sq.push_back(cs);
      if (sq.size() > 2) void'(sq.pop_front());
   endtask

   task automatic check_outputs();
      chk("cup_motor",  Cup_motor,  ph == M_DROP);
      chk("valve_open", Valve_open, ph == M_POUR);
      chk("cup_rdy",    Cup_rdy,    ph == M_CUPOK);
      chk("cof_rdy",    Cof_rdy,    ph == M_COFOK);
      chk("busy",       Busy,       ph != M_IDLE);
      chk("fault",      Fault,      ph == M_FAULT);
   endtask

   task automatic tick();
      @(posedge Clock);
      model_edge(Place_cup, Inject_cof, Cup_sensor);
      #1;
      check_outputs();
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      #2 Reset_n = 1'b0;
      #1;
      chk("rst_cup_rdy",    Cup_rdy,    0);
      chk("rst_cof_rdy",    Cof_rdy,    0);
      chk("rst_cup_motor",  Cup_motor,  0);
      chk("rst_valve_open", Valve_open, 0);
      chk("rst_busy",       Busy,       0);
      chk("rst_fault",      Fault,      0);
      ph = M_IDLE;
      sq.delete();
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   function automatic logic dut_shows(input mphase_t p);
      case (p)
         M_IDLE:  return !Busy;
         M_DROP:  return Cup_motor;
         M_CUPOK: return Cup_rdy;
         M_POUR:  return Valve_open;
         M_COFOK: return Cof_rdy;
         M_FAULT: return Fault;
         default: return Busy && !Cup_motor && !Cup_rdy && !Valve_open && !Cof_rdy && !Fault;
      endcase
   endfunction

   task automatic run_until(input mphase_t tgt, input int budget, input string tag);
      int n = 0;
      while (ph != tgt && n < budget) begin
         tick();
         n++;
      end
      chk(tag, dut_shows(tgt), 1);
   endtask

   // Counts consecutive cycles an output stays high, bounded.
   task automatic count_high(input int which, output int cnt);
      cnt = 0;
      while (((which == 0) ? Cup_motor : Valve_open) && cnt < 1000) begin
         cnt++;
         tick();
      end
   endtask

   initial begin
      int c;
      do_reset();

      // Nominal cycle.
      Cup_sensor = 1'b1;
      repeat (8) tick();
      Place_cup = 1'b1;
      tick();
      count_high(0, c);
      chk("drop_len", c, CUP_N);
      chk("cup_rdy_after_drop", Cup_rdy, 1);
      Place_cup = 1'b0;
      tick();
      chk("cup_rdy_fall", Cup_rdy, 0);
      Inject_cof = 1'b1;
      tick();
      count_high(1, c);
      chk("pour_len", c, POUR_N);
      chk("cof_rdy_after_pour", Cof_rdy, 1);
      Inject_cof = 1'b0;
      tick();
      chk("cof_rdy_fall", Cof_rdy, 0);
      // Re-request while the cup is still present.
      Place_cup = 1'b1;
      repeat (3) tick();
      chk("no_redrop", Cup_motor, 0);
      Place_cup = 1'b0;
      Cup_sensor = 1'b0;
      run_until(M_IDLE, 10, "remove_to_idle");

      // Missing cup.
      repeat (3) tick();
      Place_cup = 1'b1;
      tick();
      count_high(0, c);
      chk("drop_len_missing", c, CUP_N);
      chk("missing_fault", Fault, 1);
      chk("missing_no_rdy", Cup_rdy, 0);
      tick();
      chk("fault_held", Fault, 1);
      Place_cup = 1'b0;
      tick();
      chk("fault_clear", Busy, 0);

      // Cup pulled mid-pour.
      Cup_sensor = 1'b1;
      repeat (3) tick();
      Place_cup = 1'b1;
      run_until(M_CUPOK, 20, "reach_cup_ok");
      Place_cup = 1'b0;
      tick();
      Inject_cof = 1'b1;
      repeat (3) tick();
      Cup_sensor = 1'b0;
      repeat (3) tick();
      chk("pull_valve_off", Valve_open, 0);
      chk("pull_fault", Fault, 1);
      chk("pull_no_cof_rdy", Cof_rdy, 0);
      Inject_cof = 1'b0;
      tick();
      chk("pull_fault_clear", Busy, 0);

      // Both requests together, then reset mid-pour.
      Cup_sensor = 1'b1;
      repeat (3) tick();
      Place_cup = 1'b1;
      Inject_cof = 1'b1;
      tick();
      chk("both_drop", Cup_motor, 1);
      chk("both_no_valve", Valve_open, 0);
      run_until(M_CUPOK, 20, "both_cup_ok");
      Place_cup = 1'b0;
      repeat (4) tick();
      chk("in_pour", Valve_open, 1);
      do_reset();
      Inject_cof = 1'b0;
      repeat (3) tick();
      Place_cup = 1'b1;
      tick();
      count_high(0, c);
      chk("drop_len_after_reset", c, CUP_N);
      Place_cup = 1'b0;
      tick();
      Cup_sensor = 1'b0;
      run_until(M_IDLE, 10, "hold_to_idle");

      // Inject_cof alone in IDLE.
      Inject_cof = 1'b1;
      repeat (4) tick();
      chk("ic_alone_busy", Busy, 0);
      chk("ic_alone_valve", Valve_open, 0);
      Inject_cof = 1'b0;
      tick();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0)   Place_cup  = ~Place_cup;
         if ($urandom_range(0, 5) == 0)   Inject_cof = ~Inject_cof;
         if ($urandom_range(0, 14) == 0)  Cup_sensor = ~Cup_sensor;
         if ($urandom_range(0, 599) == 0) do_reset();
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
